// File: rtl/probe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : probe_pkg
// Purpose  : Shared member map, constant values and response type for the
//            probe responder.
// Revision : 1.0 - initial release
// ============================================================================
package probe_pkg;

    localparam logic [3:0] c_addr_p     = 4'd0;
    localparam logic [3:0] c_addr_l     = 4'd1;
    localparam logic [3:0] c_addr_w     = 4'd2;
    localparam logic [3:0] c_addr_x     = 4'd3;
    localparam logic [3:0] c_addr_f     = 4'd4;
    localparam logic [3:0] c_addr_t     = 4'd5;
    localparam logic [3:0] c_addr_blk_p = 4'd6;
    localparam logic [3:0] c_addr_blk_l = 4'd7;
    localparam logic [3:0] c_addr_blk_w = 4'd8;
    localparam logic [3:0] c_addr_blk_f = 4'd9;
    localparam logic [3:0] c_addr_blk_t = 4'd10;

    localparam logic [7:0] c_val_p     = 8'h01;
    localparam logic [7:0] c_val_l     = 8'h02;
    localparam logic [7:0] c_val_f     = 8'h0F;
    localparam logic [7:0] c_val_blk_p = 8'h04;
    localparam logic [7:0] c_val_blk_l = 8'h06;
    localparam logic [7:0] c_val_blk_f = 8'h08;

    localparam logic [3:0] c_rst_w     = 4'h3;
    localparam logic [3:0] c_rst_blk_w = 4'h7;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } rsp_t;

    localparam rsp_t c_rsp_err = '{data: 8'h00, err: 1'b1};

    function automatic rsp_t f_ok(input logic [7:0] data);
        return '{data: data, err: 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/iface_probe_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : iface_probe_responder_if
// Purpose  : Request/response handshake bundle between a prober and the
//            probe responder.
// Revision : 1.0 - initial release
// ============================================================================
interface iface_probe_responder_if;

    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface
`default_nettype wire

// File: rtl/probe_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : probe_rsp_fifo
// Purpose  : Small in-order response queue; head is presented while non-empty.
// Revision : 1.0 - initial release
// ============================================================================
module probe_rsp_fifo
    import probe_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  i_push,
    input  rsp_t i_push_data,
    input  wire  i_pop,
    output rsp_t o_pop_data,
    output logic o_full,
    output logic o_empty
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    rsp_t               r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_push;
    logic w_pop;

    function automatic logic [c_ptr_w-1:0] f_next(input logic [c_ptr_w-1:0] ptr);
        return (ptr == c_ptr_w'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign o_full     = (r_count == c_cnt_w'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    // Empty head reads as zero so the outputs are quiet while idle and in reset.
    assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= f_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/iface_probe_responder.sv
`default_nettype none
// ============================================================================
// Module   : iface_probe_responder
// Purpose  : Decodes probe reads/writes against the member map and returns
//            one queued response per accepted request.
// Revision : 1.0 - initial release
// ============================================================================
module iface_probe_responder
    import probe_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input wire                      clk,
    input wire                      rst_n,
    iface_probe_responder_if.slave  bus
);

    logic [3:0] r_w;
    logic [3:0] r_blk_w;
    logic [7:0] r_t;
    logic [7:0] r_blk_t;

    logic [3:0] w_nxt_w;
    logic [3:0] w_nxt_blk_w;
    logic [7:0] w_nxt_t;
    logic [7:0] w_nxt_blk_t;
    rsp_t       w_rsp;
    rsp_t       w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_accept;
    logic       w_unused_wdata;

    assign w_accept       = bus.req_valid && bus.req_ready;
    assign w_unused_wdata = &{1'b0, bus.req_wdata[7:4]};

    // Response is formed from the pre-access state plus this request's update,
    // so a write is visible to the very next accepted request.
    always_comb begin
        w_rsp       = c_rsp_err;
        w_nxt_w     = r_w;
        w_nxt_blk_w = r_blk_w;
        w_nxt_t     = r_t;
        w_nxt_blk_t = r_blk_t;
        case (bus.req_addr)
            c_addr_p:     if (!bus.req_write) w_rsp = f_ok(c_val_p);
            c_addr_l:     if (!bus.req_write) w_rsp = f_ok(c_val_l);
            c_addr_x:     if (!bus.req_write) w_rsp = f_ok({4'h0, r_w} + 8'h01);
            c_addr_f:     if (!bus.req_write) w_rsp = f_ok(c_val_f);
            c_addr_blk_p: if (!bus.req_write) w_rsp = f_ok(c_val_blk_p);
            c_addr_blk_l: if (!bus.req_write) w_rsp = f_ok(c_val_blk_l);
            c_addr_blk_f: if (!bus.req_write) w_rsp = f_ok(c_val_blk_f);
            c_addr_w: begin
                if (bus.req_write) w_nxt_w = bus.req_wdata[3:0];
                w_rsp = f_ok({4'h0, w_nxt_w});
            end
            c_addr_blk_w: begin
                if (bus.req_write) w_nxt_blk_w = bus.req_wdata[3:0];
                w_rsp = f_ok({4'h0, w_nxt_blk_w});
            end
            c_addr_t: begin
                if (bus.req_write) w_nxt_t = r_t + 8'h01;
                w_rsp = f_ok(w_nxt_t);
            end
            c_addr_blk_t: begin
                if (bus.req_write) w_nxt_blk_t = r_blk_t + 8'h01;
                w_rsp = f_ok(w_nxt_blk_t);
            end
            default: w_rsp = c_rsp_err;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w     <= c_rst_w;
            r_blk_w <= c_rst_blk_w;
            r_t     <= 8'h00;
            r_blk_t <= 8'h00;
        end else if (w_accept) begin
            r_w     <= w_nxt_w;
            r_blk_w <= w_nxt_blk_w;
            r_t     <= w_nxt_t;
            r_blk_t <= w_nxt_blk_t;
        end
    end

    probe_rsp_fifo #(
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_accept),
        .i_push_data (w_rsp),
        .i_pop       (bus.rsp_ready),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign bus.req_ready = !w_full;
    assign bus.rsp_valid = !w_empty;
    assign bus.rsp_data  = w_head.data;
    assign bus.rsp_err   = w_head.err;

endmodule
`default_nettype wire

// File: tb/tb_iface_probe_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_iface_probe_responder
// Purpose  : Directed scenarios plus random traffic against a member-map model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iface_probe_responder;

    localparam int DEPTH = 2;

    typedef struct {
        logic [7:0] d;
        logic       e;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    int   m_w, m_bw, m_t, m_bt;
    exp_t q[$];
    exp_t got[$];

    always #5 clk = ~clk;

    iface_probe_responder_if bus();

    iface_probe_responder #(
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_w  = 3;
        m_bw = 7;
        m_t  = 0;
        m_bt = 0;
        q.delete();
    endtask

    // Member map from the table: constants, two 4-bit registers, two counters.
    function automatic exp_t model_access(input bit wr, input int a, input int d);
        exp_t r;
        r.d = 8'h00;
        r.e = 1'b1;
        if (a == 2) begin
            if (wr) m_w = d % 16;
            r.d = 8'(m_w); r.e = 1'b0;
        end else if (a == 8) begin
            if (wr) m_bw = d % 16;
            r.d = 8'(m_bw); r.e = 1'b0;
        end else if (a == 5) begin
            if (wr) m_t = (m_t + 1) % 256;
            r.d = 8'(m_t); r.e = 1'b0;
        end else if (a == 10) begin
            if (wr) m_bt = (m_bt + 1) % 256;
            r.d = 8'(m_bt); r.e = 1'b0;
        end else if (!wr && a <= 9) begin
            r.e = 1'b0;
            case (a)
                0: r.d = 8'h01;
                1: r.d = 8'h02;
                3: r.d = 8'(m_w + 1);
                4: r.d = 8'h0F;
                6: r.d = 8'h04;
                7: r.d = 8'h06;
                default: r.d = 8'h08;
            endcase
        end
        return r;
    endfunction

    task automatic eval();
        exp_t r;
        chk("req_ready", 32'(bus.req_ready), 32'(q.size() < DEPTH));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(q.size() != 0));
        if (q.size() != 0 && bus.rsp_valid) begin
            chk("rsp_data", 32'(bus.rsp_data), 32'(q[0].d));
            chk("rsp_err", 32'(bus.rsp_err), 32'(q[0].e));
            if (bus.rsp_ready) got.push_back(q.pop_front());
        end
        if (bus.req_valid && bus.req_ready) begin
            r = model_access(bus.req_write, int'(bus.req_addr), int'(bus.req_wdata));
            q.push_back(r);
        end
    endtask

    task automatic cyc(input bit v, input bit wr, input logic [3:0] a,
                       input logic [7:0] d, input bit rr, output bit acc);
        bus.req_valid = v;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.rsp_ready = rr;
        @(negedge clk);
        acc = v && bus.req_ready;
        eval();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit wr, input logic [3:0] a, input logic [7:0] d);
        bit acc;
        int n;
        n = 0;
        do begin
            cyc(1'b1, wr, a, d, 1'b1, acc);
            n++;
        end while (!acc && n < 20);
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            cyc(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, acc);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    function automatic logic [8:0] got_at(input int i);
        if (i < got.size()) return {got[i].d, got[i].e};
        return 9'h1FF;
    endfunction

    initial begin
        bit acc;
        bit acc_seq [3];
        logic [7:0] s1_addr [9];
        logic [7:0] s1_exp  [9];
        s1_addr = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd9};
        s1_exp  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0F, 8'h04, 8'h06, 8'h07, 8'h08};

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 4'h0;
        bus.req_wdata = 8'h00;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'h00);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Scenario 1: back-to-back reads of every readable constant/register
        got.delete();
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 1'b0, s1_addr[i][3:0], 8'h00, 1'b1, acc);
            chk("s1_accept", 32'(acc), 32'd1);
        end
        drain();
        chk("s1_count", 32'(got.size()), 32'd9);
        for (int i = 0; i < 9; i++) chk("s1_data", 32'(got_at(i)), 32'({s1_exp[i], 1'b0}));

        // Scenario 2: write w then read x and w
        got.delete();
        send(1'b1, 4'd2, 8'hAE);
        send(1'b0, 4'd3, 8'h00);
        send(1'b0, 4'd2, 8'h00);
        drain();
        chk("s2_w_wr", 32'(got_at(0)), 32'({8'h0E, 1'b0}));
        chk("s2_x", 32'(got_at(1)), 32'({8'h0F, 1'b0}));
        chk("s2_w_rd", 32'(got_at(2)), 32'({8'h0E, 1'b0}));

        // Scenario 3: 257 invocations wrap the counter to 1
        for (int i = 0; i < 257; i++) send(1'b1, 4'd5, 8'(i));
        drain();
        got.delete();
        send(1'b0, 4'd5, 8'h00);
        drain();
        chk("s3_t", 32'(got_at(0)), 32'({8'h01, 1'b0}));

        // Scenario 4: RO write and unmapped read both error, P unaffected
        got.delete();
        send(1'b1, 4'd0, 8'h55);
        send(1'b0, 4'd12, 8'h00);
        send(1'b0, 4'd0, 8'h00);
        drain();
        chk("s4_ro_wr", 32'(got_at(0)), 32'({8'h00, 1'b1}));
        chk("s4_unmap", 32'(got_at(1)), 32'({8'h00, 1'b1}));
        chk("s4_p", 32'(got_at(2)), 32'({8'h01, 1'b0}));

        // Scenario 5: backpressure fills the queue, then releases in order
        got.delete();
        cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, acc_seq[0]);
        cyc(1'b1, 1'b0, 4'd1, 8'h00, 1'b0, acc_seq[1]);
        cyc(1'b1, 1'b0, 4'd4, 8'h00, 1'b0, acc_seq[2]);
        chk("s5_acc0", 32'(acc_seq[0]), 32'd1);
        chk("s5_acc1", 32'(acc_seq[1]), 32'd1);
        chk("s5_acc2", 32'(acc_seq[2]), 32'd0);
        cyc(1'b1, 1'b0, 4'd4, 8'h00, 1'b0, acc);
        chk("s5_held_ready", 32'(acc), 32'd0);
        send(1'b0, 4'd4, 8'h00);
        drain();
        chk("s5_count", 32'(got.size()), 32'd3);
        chk("s5_r0", 32'(got_at(0)), 32'({8'h01, 1'b0}));
        chk("s5_r1", 32'(got_at(1)), 32'({8'h02, 1'b0}));
        chk("s5_r2", 32'(got_at(2)), 32'({8'h0F, 1'b0}));

        // Scenario 6: reset with two responses queued and blk.w modified
        send(1'b1, 4'd8, 8'h01);
        drain();
        cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, acc);
        cyc(1'b1, 1'b0, 4'd1, 8'h00, 1'b0, acc);
        chk("s6_queued", 32'(bus.rsp_valid), 32'd1);
        bus.req_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("s6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("s6_req_ready", 32'(bus.req_ready), 32'd1);
        chk("s6_rsp_data", 32'(bus.rsp_data), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        got.delete();
        send(1'b0, 4'd8, 8'h00);
        send(1'b0, 4'd5, 8'h00);
        drain();
        chk("s6_count", 32'(got.size()), 32'd2);
        chk("s6_blk_w", 32'(got_at(0)), 32'({8'h07, 1'b0}));
        chk("s6_t", 32'(got_at(1)), 32'({8'h00, 1'b0}));

        // Random traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 8'($urandom),
                ($urandom_range(0, 3) != 0), acc);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
